// File: rtl/traffic_light_fsm.sv
// Two-road traffic light controller. Road A is the main road and road B the side road.
// All timing is counted in upstream ticks, and the sensor inputs are synchronized before the FSM uses them.
module traffic_light_fsm #(
  parameter int TW           = 8,
  parameter int GREEN_MIN    = 5,
  parameter int GREEN_MAX    = 10,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ta,
  input  logic       tb,
  output logic [2:0] la,
  output logic [2:0] lb,
  output logic [2:0] state_o
);

  if (GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN || YELLOW_TICKS < 1 || ALLRED_TICKS < 1 ||
      GREEN_MAX > (2**TW) - 1 || GREEN_MIN > (2**TW) - 1 ||
      YELLOW_TICKS > (2**TW) - 1 || ALLRED_TICKS > (2**TW) - 1) begin : g_param_err
    $error("traffic_light_fsm: illegal duration parameters");
  end

  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    AB_RED = 3'd2,
    B_GRN  = 3'd3,
    B_YEL  = 3'd4,
    BA_RED = 3'd5
  } state_t;

  localparam logic [TW-1:0] C_GMIN = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] C_GMAX = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] C_YEL  = TW'(YELLOW_TICKS - 1);
  localparam logic [TW-1:0] C_ARED = TW'(ALLRED_TICKS - 1);

  function automatic logic [2:0] f_la(input state_t s);
    case (s)
      A_GRN:   f_la = 3'b001;
      A_YEL:   f_la = 3'b010;
      default: f_la = 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] f_lb(input state_t s);
    case (s)
      B_GRN:   f_lb = 3'b001;
      B_YEL:   f_lb = 3'b010;
      default: f_lb = 3'b100;
    endcase
  endfunction

  logic          r_ta_m, r_ta_s, r_tb_m, r_tb_s;
  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_la, r_lb;

  state_t        w_next;
  logic          w_adv;
  logic          w_bad;
  logic [TW-1:0] w_timer_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ta_m <= 1'b0;
      r_ta_s <= 1'b0;
      r_tb_m <= 1'b0;
      r_tb_s <= 1'b0;
    end else begin
      r_ta_m <= ta;
      r_ta_s <= r_ta_m;
      r_tb_m <= tb;
      r_tb_s <= r_tb_m;
    end
  end

  assign w_timer_inc = (r_timer == {TW{1'b1}}) ? r_timer : r_timer + TW'(1);

  always_comb begin
    w_next = r_state;
    w_adv  = 1'b0;
    w_bad  = 1'b0;
    case (r_state)
      A_GRN: begin
        w_next = A_YEL;
        w_adv  = (r_timer >= C_GMIN) && r_tb_s && (!r_ta_s || (r_timer >= C_GMAX));
      end
      A_YEL: begin
        w_next = AB_RED;
        w_adv  = (r_timer == C_YEL);
      end
      AB_RED: begin
        w_next = B_GRN;
        w_adv  = (r_timer == C_ARED);
      end
      B_GRN: begin
        w_next = B_YEL;
        w_adv  = (r_timer >= C_GMIN) && r_ta_s && (!r_tb_s || (r_timer >= C_GMAX));
      end
      B_YEL: begin
        w_next = BA_RED;
        w_adv  = (r_timer == C_YEL);
      end
      BA_RED: begin
        w_next = A_GRN;
        w_adv  = (r_timer == C_ARED);
      end
      default: begin
        // Corrupted encodings recover to all-red without waiting for a tick.
        w_next = AB_RED;
        w_adv  = 1'b1;
        w_bad  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= A_GRN;
      r_timer <= '0;
      r_la    <= 3'b001;
      r_lb    <= 3'b100;
    end else if (tick || w_bad) begin
      if (w_adv) begin
        r_state <= w_next;
        r_timer <= '0;
        r_la    <= f_la(w_next);
        r_lb    <= f_lb(w_next);
      end else begin
        r_timer <= w_timer_inc;
      end
    end
  end

  assign la      = r_la;
  assign lb      = r_lb;
  assign state_o = r_state;

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Two-road intersection controller (road A = main, road B = side) that consumes the one-cycle `tick` pulse from the upstream clock-divider stage.
- Sequences red/yellow/green lamps for both roads. All timing is counted in ticks; every other clock cycle is ignored.
- Green for A is extended by the traffic sensors, with a bounded maximum; B is symmetric.
- Its outputs drive the board lamp/LED pins directly.

Parameters:
- TW, 8, width of the tick timer.
- GREEN_MIN, 5, minimum green duration in ticks (>=1).
- GREEN_MAX, 10, maximum green duration in ticks while the other road is waiting (>=GREEN_MIN).
- YELLOW_TICKS, 2, yellow duration in ticks (>=1).
- ALLRED_TICKS, 1, all-red clearance duration in ticks (>=1).
- All four durations must be <= 2^TW-1; elaboration fails otherwise.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- tick  input  1  one-clk-wide timing pulse from the upstream divider; it may also be held high continuously.
- ta  input  1  traffic present on road A; asynchronous to clk.
- tb  input  1  traffic present on road B; asynchronous to clk.
- la  output  3  road A lamps {red,yellow,green}; exactly one bit set.
- lb  output  3  road B lamps {red,yellow,green}; exactly one bit set.
- state_o  output  3  current state encoding, for debug/LEDs.

Behaviour:
- Sensor input: ta and tb each pass through a 2-flop synchronizer clocked by clk and reset by reset. The FSM uses only the synchronized values.
- States (state_o encoding):
  - A_GRN=0: la=001, lb=100.
  - A_YEL=1: la=010, lb=100.
  - AB_RED=2: la=100, lb=100.
  - B_GRN=3: la=100, lb=001.
  - B_YEL=4: lb=010, la=100.
  - BA_RED=5: la=100, lb=100.
  - Codes 6 and 7 are illegal and go to AB_RED on the next clk edge, regardless of tick.
- Moore machine. la, lb and state_o are registered and update on the same edge as the state register.
- Reset (asynchronous, while reset=0): state=A_GRN, timer=0, la=001, lb=100, state_o=0, synchronizers cleared to 0. After reset is released, operation starts on the first tick.
- Reset asserted mid-sequence (e.g. during B_YEL) forces A_GRN immediately, without waiting for clk.
- Edges with tick=0: state, timer and outputs hold. Sensor values between ticks are not latched; they matter only at tick edges.
- Timer semantics: timer counts ticks spent in the current state.
  - On a tick edge that transitions, timer <= 0.
  - On any other tick edge, timer <= timer+1, saturating at 2^TW-1.
  - All conditions below use the timer value before the update.
- A_GRN -> A_YEL on tick when timer >= GREEN_MIN-1 AND tb_s=1 AND (ta_s=0 OR timer >= GREEN_MAX-1).
  - Otherwise A_GRN is held; with tb_s=0 it stays indefinitely.
- A_YEL -> AB_RED on tick when timer == YELLOW_TICKS-1.
- AB_RED -> B_GRN on tick when timer == ALLRED_TICKS-1.
- B_GRN -> B_YEL: same rule as A_GRN with ta/tb swapped.
- B_YEL -> BA_RED on tick when timer == YELLOW_TICKS-1.
- BA_RED -> A_GRN on tick when timer == ALLRED_TICKS-1.
- Resulting durations:
  - Yellow lasts exactly YELLOW_TICKS ticks.
  - All-red lasts exactly ALLRED_TICKS ticks.
  - Green lasts between GREEN_MIN and GREEN_MAX ticks whenever the other road is requesting.
- Safety invariants, which must hold on every cycle:
  - Never is any non-red lamp lit on both roads at once.
  - la and lb are each one-hot.
  - Every green-to-green change passes through yellow then all-red.
- tick stuck high: each clk counts as one tick; behaviour is the same, just faster. No special handling.

Test Plan:
All scenarios use GREEN_MIN=3, GREEN_MAX=6, YELLOW_TICKS=2, ALLRED_TICKS=1, with tick pulsed every 4 clks unless noted.
1. Reset and idle: reset=0 then released; ta=1, tb=0; 20 ticks -> la=001, lb=100, state_o=0 throughout, with no transition.
2. Side-road request: ta=0, tb=1 from reset -> A_GRN held for 3 ticks; then A_YEL for 2 ticks; AB_RED for 1 tick; then B_GRN (lb=001, la=100).
3. Max-green cap: ta=1, tb=1 constantly -> A_GRN lasts exactly 6 ticks, B_GRN lasts exactly 6 ticks, and the full 6-state cycle repeats with period 18 ticks.
4. Sensor change between ticks: tb pulsed high for 1 clk, strictly between two ticks -> no transition ever occurs.
5. Reset mid-operation: reset asserted mid-clk during B_YEL -> la=001, lb=100 and state_o=0 immediately (asynchronously); after release, the timer restarts from 0.
6. Continuous tick (tick=1) with ta=0, tb=1 -> A_GRN lasts 3 clks and A_YEL 2 clks. The invariant checker (no simultaneous non-red lamps on both roads, one-hot outputs) passes for 10k random ta/tb cycles.
